// File: rtl/riscv_defines.sv
// Shared datapath widths and the writeback request record used by the
// writeback merge stage.
package riscv_defines;
  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  typedef struct packed {
    logic             vld;
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;
endpackage

// File: rtl/asa_riscv_tag_fifo.sv
// Small FIFO holding destination tags of multiplies still in flight.
// Power-of-two depth; push and pop may coincide even when full.
module asa_riscv_tag_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/asa_riscv_mul_wb.sv
// Writeback merge: pairs multiplier results with their issued rd, merges them
// with the ALU stream into one register-file write port, parking displaced ALU results.
module asa_riscv_mul_wb #(
  parameter int XLEN      = riscv_defines::XLEN,
  parameter int RF_AW     = riscv_defines::RF_AW,
  parameter int TAG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             mul_issue,
  input  logic [RF_AW-1:0] mul_rd,
  input  logic             mul_bubble,
  input  logic [XLEN-1:0]  mul_r,
  input  logic             alu_vld,
  input  logic [RF_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_r,
  output logic             wb_we,
  output logic [RF_AW-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_stall,
  output logic             orphan
);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  riscv_defines::wb_req_t hold;
  riscv_defines::wb_req_t hold_nxt;
  riscv_defines::wb_req_t win_p0;
  riscv_defines::wb_req_t wb_p1;

  logic [RF_AW-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   drop_cnt;
  logic [CNT_W:0]   drop_nxt;
  logic             mul_vld_p0;
  logic             absorb;
  logic             fifo_pop;
  logic             orphan_hit;
  logic             alu_ok;
  logic             issue_ok;

  // Results still in flight at a flush are older than the flush and drain
  // ahead of anything issued later, so the drop counter claims them first.
  always_comb begin
    mul_vld_p0 = ~mul_bubble;
    absorb     = mul_vld_p0 & (drop_cnt != '0);
    fifo_pop   = mul_vld_p0 & ~absorb & ~fifo_empty;
    orphan_hit = mul_vld_p0 & ~absorb & fifo_empty;
    wb_stall   = hold.vld | (fifo_full & ~fifo_pop);
    alu_ok     = alu_vld & ~wb_stall;
    issue_ok   = mul_issue & ~wb_stall & ~flush;
  end

  asa_riscv_tag_fifo #(
    .WIDTH (RF_AW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue_ok),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (mul_rd),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    win_p0   = '0;
    hold_nxt = hold;
    if (fifo_pop) begin
      win_p0 = '{vld: 1'b1, rd: fifo_head, data: mul_r};
      if (alu_ok) hold_nxt = '{vld: 1'b1, rd: alu_rd, data: alu_r};
    end else if (hold.vld) begin
      win_p0   = hold;
      hold_nxt = '{vld: alu_ok, rd: alu_rd, data: alu_r};
    end else if (alu_ok) begin
      win_p0 = '{vld: 1'b1, rd: alu_rd, data: alu_r};
    end
    if (flush) hold_nxt.vld = 1'b0;
  end

  always_comb begin
    drop_nxt = drop_cnt - {{CNT_W{1'b0}}, absorb};
    if (flush) drop_nxt = drop_nxt + {1'b0, fifo_count} - {{CNT_W{1'b0}}, fifo_pop};
  end

  // ---- p0 -> p1: registered write port, hold register and control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_p1    <= '0;
      hold.vld <= 1'b0;
      drop_cnt <= '0;
      orphan   <= 1'b0;
    end else begin
      wb_p1.vld  <= win_p0.vld & (win_p0.rd != '0);
      wb_p1.rd   <= win_p0.rd;
      wb_p1.data <= win_p0.data;
      hold       <= hold_nxt;
      drop_cnt   <= drop_nxt;
      if (orphan_hit) orphan <= 1'b1;
    end
  end

  assign wb_we   = wb_p1.vld;
  assign wb_rd   = wb_p1.rd;
  assign wb_data = wb_p1.data;

  a_no_input_during_stall: assert property (
    @(posedge clk) disable iff (rst) wb_stall |-> !(alu_vld || mul_issue));
endmodule
